// File: rtl/nbody_step_sched.sv
// nbody_step_sched: central sequencer for one n-body integration run.
// Walks the (i,j) pair space for the acceleration pipeline, delays issue tags by the
// pipeline latency so velocity accumulation sees aligned valid/first/last flags, then
// sweeps the position-update pass, repeating for the programmed number of steps.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_go                    software run request (level); dropping it while busy aborts
//   i_num_bodies            body count N (clamped to BODIES), sampled at start
//   i_num_steps             steps per run (0 treated as 1), sampled at start
//   o_busy, o_done, o_phase run status; phase 0=idle/done, 1=accel, 2=pos
//   o_pair_*                pair issue to the acceleration datapath
//   o_acc_*                 latency-aligned acceleration result tags
//   o_pos_rd_addr           position/velocity read address during POS
//   o_pos_wr_en/_addr       position write strobe, ADD_LATENCY after the read
//   o_step_count            completed steps in the current run
module nbody_step_sched #(
  parameter int unsigned BODIES          = 512,
  parameter int unsigned BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int unsigned ACCL_LATENCY    = 131,
  parameter int unsigned ADD_LATENCY     = 20,
  parameter int unsigned STEP_WIDTH      = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_go,
  input  logic [BODY_ADDR_WIDTH:0]   i_num_bodies,
  input  logic [STEP_WIDTH-1:0]      i_num_steps,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_phase,
  output logic [BODY_ADDR_WIDTH-1:0] o_pair_i,
  output logic [BODY_ADDR_WIDTH-1:0] o_pair_j,
  output logic                       o_pair_valid,
  output logic                       o_pair_self,
  output logic                       o_acc_valid,
  output logic [BODY_ADDR_WIDTH-1:0] o_acc_i,
  output logic                       o_acc_first,
  output logic                       o_acc_last,
  output logic [BODY_ADDR_WIDTH-1:0] o_pos_rd_addr,
  output logic                       o_pos_wr_en,
  output logic [BODY_ADDR_WIDTH-1:0] o_pos_wr_addr,
  output logic [STEP_WIDTH-1:0]      o_step_count
);

  localparam int unsigned NW      = BODY_ADDR_WIDTH + 1;
  localparam int unsigned MAX_LAT = (ACCL_LATENCY > ADD_LATENCY) ? ACCL_LATENCY : ADD_LATENCY;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {StIdle, StAccel, StDrainA, StPos, StDrainP, StDone} state_e;

  typedef struct packed {
    logic                       valid;
    logic                       first;
    logic                       last;
    logic [BODY_ADDR_WIDTH-1:0] idx;
  } acc_tap_t;

  typedef struct packed {
    logic                       valid;
    logic [BODY_ADDR_WIDTH-1:0] addr;
  } wr_tap_t;

  state_e                     r_state, w_state_d;
  logic [NW-1:0]              r_n;
  logic [STEP_WIDTH-1:0]      r_steps, r_step_count;
  logic [BODY_ADDR_WIDTH-1:0] r_i, r_j, r_p;
  logic [CW-1:0]              r_cnt;
  acc_tap_t                   r_acc [ACCL_LATENCY];
  wr_tap_t                    r_wr  [ADD_LATENCY];

  logic [NW-1:0] w_n_clamp, w_last;
  logic          w_busy, w_abort, w_issue, w_rd;
  logic          w_i_last, w_j_last, w_p_last, w_a_end, w_p_end, w_step_last;
  acc_tap_t      w_acc_in;
  wr_tap_t       w_wr_in;

  assign w_n_clamp   = (i_num_bodies > NW'(BODIES)) ? NW'(BODIES) : i_num_bodies;
  assign w_last      = r_n - NW'(1);
  assign w_busy      = (r_state == StAccel) || (r_state == StDrainA) ||
                       (r_state == StPos)   || (r_state == StDrainP);
  assign w_abort     = w_busy && !i_go;
  assign w_issue     = (r_state == StAccel);
  assign w_rd        = (r_state == StPos);
  assign w_i_last    = ({1'b0, r_i} == w_last);
  assign w_j_last    = ({1'b0, r_j} == w_last);
  assign w_p_last    = ({1'b0, r_p} == w_last);
  assign w_a_end     = (r_cnt == CW'(ACCL_LATENCY - 1));
  assign w_p_end     = (r_cnt == CW'(ADD_LATENCY - 1));
  assign w_step_last = ((r_step_count + STEP_WIDTH'(1)) == r_steps);

  // Tags are zeroed when nothing is issued so the delayed outputs read 0 when idle.
  assign w_acc_in.valid = w_issue;
  assign w_acc_in.first = w_issue && (r_j == '0);
  assign w_acc_in.last  = w_issue && w_j_last;
  assign w_acc_in.idx   = w_issue ? r_i : '0;
  assign w_wr_in.valid  = w_rd;
  assign w_wr_in.addr   = w_rd ? r_p : '0;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (i_go) w_state_d = (w_n_clamp == '0) ? StDone : StAccel;
      StAccel:  if (!i_go) w_state_d = StIdle;
                else if (w_i_last && w_j_last) w_state_d = StDrainA;
      StDrainA: if (!i_go) w_state_d = StIdle;
                else if (w_a_end) w_state_d = StPos;
      StPos:    if (!i_go) w_state_d = StIdle;
                else if (w_p_last) w_state_d = StDrainP;
      StDrainP: if (!i_go) w_state_d = StIdle;
                else if (w_p_end) w_state_d = w_step_last ? StDone : StAccel;
      StDone:   if (!i_go) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_n          <= '0;
      r_steps      <= '0;
      r_step_count <= '0;
      r_i          <= '0;
      r_j          <= '0;
      r_p          <= '0;
      r_cnt        <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && i_go) begin
        r_n          <= w_n_clamp;
        r_steps      <= (i_num_steps == '0) ? STEP_WIDTH'(1) : i_num_steps;
        r_step_count <= '0;
      end
      // Pair counters rest at (0,0) outside ACCEL so every step restarts cleanly.
      if (w_issue && w_state_d == StAccel) begin
        if (w_j_last) begin
          r_j <= '0;
          r_i <= r_i + BODY_ADDR_WIDTH'(1);
        end else begin
          r_j <= r_j + BODY_ADDR_WIDTH'(1);
        end
      end else begin
        r_i <= '0;
        r_j <= '0;
      end
      r_p   <= (w_rd && w_state_d == StPos) ? r_p + BODY_ADDR_WIDTH'(1) : '0;
      r_cnt <= (w_state_d == r_state) ? r_cnt + CW'(1) : '0;
      if (r_state == StDrainP && w_p_end && i_go) r_step_count <= r_step_count + STEP_WIDTH'(1);
    end
  end

  // Latency-matching delay lines; an abort flushes them so no stale result or write escapes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < ACCL_LATENCY; k++) r_acc[k] <= '0;
      for (int k = 0; k < ADD_LATENCY; k++)  r_wr[k]  <= '0;
    end else if (w_abort) begin
      for (int k = 0; k < ACCL_LATENCY; k++) r_acc[k] <= '0;
      for (int k = 0; k < ADD_LATENCY; k++)  r_wr[k]  <= '0;
    end else begin
      r_acc[0] <= w_acc_in;
      for (int k = 1; k < ACCL_LATENCY; k++) r_acc[k] <= r_acc[k-1];
      r_wr[0] <= w_wr_in;
      for (int k = 1; k < ADD_LATENCY; k++) r_wr[k] <= r_wr[k-1];
    end
  end

  always_comb begin
    o_phase = 2'd0;
    if (r_state == StAccel || r_state == StDrainA) o_phase = 2'd1;
    if (r_state == StPos || r_state == StDrainP)   o_phase = 2'd2;
  end

  assign o_busy        = w_busy;
  assign o_done        = (r_state == StDone);
  assign o_pair_valid  = w_issue;
  assign o_pair_i      = r_i;
  assign o_pair_j      = r_j;
  assign o_pair_self   = w_issue && (r_i == r_j);
  assign o_acc_valid   = r_acc[ACCL_LATENCY-1].valid;
  assign o_acc_i       = r_acc[ACCL_LATENCY-1].idx;
  assign o_acc_first   = r_acc[ACCL_LATENCY-1].first;
  assign o_acc_last    = r_acc[ACCL_LATENCY-1].last;
  assign o_pos_rd_addr = r_p;
  assign o_pos_wr_en   = r_wr[ADD_LATENCY-1].valid;
  assign o_pos_wr_addr = r_wr[ADD_LATENCY-1].addr;
  assign o_step_count  = r_step_count;

endmodule

// File: tb/tb_nbody_step_sched.sv
// Bench for nbody_step_sched with small latencies. The reference model derives every
// expected output from the cycle offset since go rose, using the run's timeline arithmetic:
// each step is N*N issue cycles, ACCL_LATENCY drain, N position reads, ADD_LATENCY drain.
module tb_nbody_step_sched;
  localparam int unsigned BODIES = 8;
  localparam int unsigned BW     = 3;
  localparam int unsigned L      = 4;
  localparam int unsigned A      = 2;
  localparam int unsigned SW     = 16;

  typedef logic [BW:0]   nb_t;
  typedef logic [SW-1:0] ns_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          go = 1'b0;
  logic [BW:0]   num_bodies = '0;
  logic [SW-1:0] num_steps = '0;
  logic          busy, done, pair_valid, pair_self, acc_valid, acc_first, acc_last, pos_wr_en;
  logic [1:0]    phase;
  logic [BW-1:0] pair_i, pair_j, acc_i, pos_rd_addr, pos_wr_addr;
  logic [SW-1:0] step_count;

  nbody_step_sched #(
    .BODIES(BODIES), .BODY_ADDR_WIDTH(BW), .ACCL_LATENCY(L), .ADD_LATENCY(A), .STEP_WIDTH(SW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_go(go), .i_num_bodies(num_bodies), .i_num_steps(num_steps),
    .o_busy(busy), .o_done(done), .o_phase(phase), .o_pair_i(pair_i), .o_pair_j(pair_j),
    .o_pair_valid(pair_valid), .o_pair_self(pair_self), .o_acc_valid(acc_valid),
    .o_acc_i(acc_i), .o_acc_first(acc_first), .o_acc_last(acc_last),
    .o_pos_rd_addr(pos_rd_addr), .o_pos_wr_en(pos_wr_en), .o_pos_wr_addr(pos_wr_addr),
    .o_step_count(step_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  typedef struct packed {
    int busy, done, phase, pv, pi, pj, psf, av, ai, af, al, rd_chk, rd, we, wa, sc_chk, sc;
  } exp_t;

  // Expected outputs t cycles after the cycle in which go rose; ta is the cycle go fell (0=never).
  function automatic exp_t model(int t, int n, int steps, int ta);
    exp_t e;
    int s_len, u, s, o, k, w;
    e = '0;
    if (ta > 0 && t > ta) return e;
    e.sc_chk = 1;
    if (n == 0) begin
      e.done = 1;
      return e;
    end
    s_len = n * n + L + n + A;
    u = t - 1;
    if (u >= steps * s_len) begin
      e.done = 1;
      e.sc = steps;
      return e;
    end
    s = u / s_len;
    o = u % s_len;
    e.sc = s;
    e.busy = 1;
    e.phase = (o < n * n + L) ? 1 : 2;
    if (o < n * n) begin
      e.pv = 1; e.pi = o / n; e.pj = o % n; e.psf = (e.pi == e.pj) ? 1 : 0;
    end
    if (o >= L && o - L < n * n) begin
      k = o - L;
      e.av = 1; e.ai = k / n;
      e.af = (k % n == 0) ? 1 : 0;
      e.al = (k % n == n - 1) ? 1 : 0;
    end
    if (o >= n * n + L && o < n * n + L + n) begin
      e.rd_chk = 1; e.rd = o - (n * n + L);
    end
    w = o - (n * n + L + A);
    if (w >= 0 && w < n) begin
      e.we = 1; e.wa = w;
    end
    return e;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_ctl"}, 32'({busy, done, phase, pair_valid, pair_i, pair_j, pair_self,
              acc_valid, acc_i, acc_first, acc_last, pos_rd_addr, pos_wr_en, pos_wr_addr}), 32'd0);
  endtask

  task automatic run(input int n_raw, input int steps_raw, input int ta, input int rst_t,
                     output int done_at);
    int n, steps, end_t, t;
    bit stop;
    exp_t e;
    n = (n_raw > int'(BODIES)) ? int'(BODIES) : n_raw;
    steps = (steps_raw == 0) ? 1 : steps_raw;
    end_t = (n == 0) ? 3 : ((ta > 0) ? ta + L + A + 3 : steps * (n * n + L + n + A) + 3);
    done_at = -1;
    stop = 0;
    @(posedge clk); #1;
    cyc = 0;
    num_bodies = nb_t'(n_raw);
    num_steps = ns_t'(steps_raw);
    go = 1'b1;
    t = 1;
    while (t <= end_t && !stop) begin
      @(posedge clk); #1;
      cyc = t;
      e = model(t, n, steps, ta);
      check_eq("busy", 32'(busy), e.busy);
      check_eq("done", 32'(done), e.done);
      check_eq("phase", 32'(phase), e.phase);
      check_eq("pair_valid", 32'(pair_valid), e.pv);
      check_eq("pair_self", 32'(pair_self), e.psf);
      if (e.pv != 0) begin
        check_eq("pair_i", 32'(pair_i), e.pi);
        check_eq("pair_j", 32'(pair_j), e.pj);
      end
      check_eq("acc_valid", 32'(acc_valid), e.av);
      if (e.av != 0) begin
        check_eq("acc_i", 32'(acc_i), e.ai);
        check_eq("acc_first", 32'(acc_first), e.af);
        check_eq("acc_last", 32'(acc_last), e.al);
      end
      if (e.rd_chk != 0) check_eq("pos_rd_addr", 32'(pos_rd_addr), e.rd);
      check_eq("pos_wr_en", 32'(pos_wr_en), e.we);
      if (e.we != 0) check_eq("pos_wr_addr", 32'(pos_wr_addr), e.wa);
      if (e.sc_chk != 0) check_eq("step_count", 32'(step_count), e.sc);
      if (done && done_at < 0) done_at = t;
      // Inputs change freely while busy; the latched values must be the ones used.
      num_bodies = nb_t'($urandom);
      num_steps = ns_t'($urandom);
      if (t == ta) go = 1'b0;
      if (t == rst_t) begin
        #1 rst_n = 1'b0;
        #1 check_idle("rst_async");
        check_eq("rst_async_steps", 32'(step_count), 32'd0);
        go = 1'b0;
        stop = 1;
      end
      t++;
    end
    if (rst_t > 0) begin
      @(posedge clk); #1;
      rst_n = 1'b1;
    end
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("after_run");
    if (ta == 0 && rst_t == 0) check_eq("final_steps", 32'(step_count), (n == 0) ? 0 : steps);
  endtask

  initial begin
    int d, nr, sr, n, st, ta;
    #12;
    check_idle("reset");
    check_eq("reset_steps", 32'(step_count), 32'd0);
    #5 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run(3, 2, 0, 0, d);
    check_eq("done_cycle", 32'(d), 32'd37);
    run(1, 1, 0, 0, d);
    run(0, 5, 0, 0, d);
    check_eq("n0_done_cycle", 32'(d), 32'd1);
    run(3, 2, 11, 0, d);
    run(3, 2, 0, 15, d);
    run(3, 1, 0, 0, d);
    run(12, 1, 0, 0, d);
    run(2, 0, 0, 0, d);

    for (int r = 0; r < 16; r++) begin
      nr = $urandom_range(0, 10);
      sr = $urandom_range(0, 3);
      n = (nr > int'(BODIES)) ? int'(BODIES) : nr;
      st = (sr == 0) ? 1 : sr;
      ta = 0;
      if (n > 0 && $urandom_range(0, 3) == 0)
        ta = $urandom_range(1, st * (n * n + L + n + A));
      run(nr, sr, ta, 0, d);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/nbody_step_sched.md
Name: nbody_step_sched

Overview:
Central sequencer for one n-body integration run. It walks the (i,j) pair space for the acceleration pipeline and tracks pipeline latency so downstream velocity accumulation knows which results are valid. It then sweeps the position-update pass and repeats for a programmed number of steps before handing control back to software. It sits between the software register file (go/done handshake) and the x/y/m/v RAMs plus the getAccl/AddSub datapath, and owns every RAM address and write strobe during compute.

Parameters:
BODIES, 512, maximum body count (RAM depth)
BODY_ADDR_WIDTH, $clog2(BODIES), body index width
ACCL_LATENCY, 131, cycles from pair issue to acceleration result valid
ADD_LATENCY, 20, AddSub latency for the position update
STEP_WIDTH, 16, width of the step counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
go  in  1  level request from software; run starts on rising level in IDLE
num_bodies  in  BODY_ADDR_WIDTH+1  bodies N (0..BODIES), sampled at start
num_steps  in  STEP_WIDTH  steps per run; 0 treated as 1; sampled at start
busy  out  1  high in any state except IDLE/DONE
done  out  1  run complete
phase  out  2  0=idle/done, 1=accel, 2=pos
pair_i  out  BODY_ADDR_WIDTH  issued body i (pos port A, m address)
pair_j  out  BODY_ADDR_WIDTH  issued body j (pos port B)
pair_valid  out  1  pair issued this cycle
pair_self  out  1  pair_i==pair_j (datapath zeroes its result)
acc_valid  out  1  acceleration result valid this cycle
acc_i  out  BODY_ADDR_WIDTH  body the result belongs to
acc_first  out  1  first j for acc_i (clear accumulator)
acc_last  out  1  last j for acc_i (commit velocity)
pos_rd_addr  out  BODY_ADDR_WIDTH  position/velocity read address
pos_wr_en  out  1  position write strobe
pos_wr_addr  out  BODY_ADDR_WIDTH  position write address
step_count  out  STEP_WIDTH  completed steps in current run

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; delay lines cleared.
- States: IDLE, ACCEL, DRAIN_A, POS, DRAIN_P, DONE.
- IDLE: when go=1, latch N and steps and go to ACCEL next cycle. If N==0, go directly to DONE with step_count=0.
- ACCEL: one pair per cycle, with pair_valid=1. Order is i outer, j inner: (0,0),(0,1)..(0,N-1),(1,0)..(N-1,N-1). j wraps to 0 and i increments. After (N-1,N-1) is issued, go to DRAIN_A. Lasts exactly N*N cycles.
- Delay line: pair_valid, pair_i, j==0 and j==N-1 are delayed by exactly ACCL_LATENCY cycles to produce acc_valid, acc_i, acc_first and acc_last. For N==1, acc_first and acc_last are both set.
- DRAIN_A: exactly ACCL_LATENCY cycles with no issue, then go to POS.
- POS: pos_rd_addr = 0..N-1, one per cycle, over N cycles, then go to DRAIN_P. A read issued in cycle t produces pos_wr_en=1 and pos_wr_addr = that address in cycle t+ADD_LATENCY.
- DRAIN_P: exactly ADD_LATENCY cycles. On exit, step_count++. If step_count+1 == steps, go to DONE; else go to ACCEL and restart at (0,0).
- DONE: done=1, busy=0. Hold until go=0, then go to IDLE with done=0 (step_count is held until the next start).
- go=0 in any busy state aborts: next cycle is IDLE, all valid/strobe delay lines are flushed, and no further writes occur. done stays 0.
- phase reflects the current state. DRAIN_A reports phase 1, DRAIN_P reports phase 2.
- num_bodies and num_steps changes while busy are ignored.
- Values of N above BODIES are clamped to BODIES.

Test Plan:
- ACCL_LATENCY=4, ADD_LATENCY=2, N=3, steps=2, go rises in cycle 0 -> ACCEL in cycles 1-9, then 19-27. acc_valid in cycles 5-13, with acc_last in cycles 7, 10 and 13. pos_wr_en in cycles 16-18 with addresses 0,1,2. done=1 from cycle 37, step_count=2.
- Same setup, check pair_self -> pair_self is high only for (0,0),(1,1),(2,2) (cycles 1, 5, 9).
- N=1, steps=1 -> 1 ACCEL cycle; acc_valid has acc_first=acc_last=1; pos_wr_en occurs once at address 0; done asserts.
- N=0 -> done=1 in the cycle after go; no pair_valid or pos_wr_en ever asserts.
- go dropped during DRAIN_A of step 1 -> IDLE next cycle; acc_valid and pos_wr_en stay 0 thereafter; done=0.
- rst pulsed low mid-POS -> all outputs 0 immediately (asynchronous); after release, IDLE; a new go starts a fresh run at (0,0) with step_count=0.
